// File: rtl/mem_exec_state_table.sv
// Execution-state table for the memory back end: tracks per-entry completion state
// between dispatch allocation at the tail and in-order retirement at the head.
module mem_exec_state_table #(
    parameter int ENTRY_NUM    = 64,
    parameter int PTR_WIDTH    = 6,
    parameter int WRITE_PORTS  = 2,
    parameter int ALLOC_WIDTH  = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int STATE_WIDTH  = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int ALLOC_CNT_W  = $clog2(ALLOC_WIDTH) + 1,
    parameter int COMMIT_CNT_W = $clog2(COMMIT_WIDTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ALLOC_CNT_W-1:0]  i_alloc_count,
    output logic [PTR_WIDTH-1:0]    o_tail_ptr,
    output logic [PTR_WIDTH:0]      o_free_count,
    input  logic                    i_wr_en    [WRITE_PORTS],
    input  logic [PTR_WIDTH-1:0]    i_wr_ptr   [WRITE_PORTS],
    input  logic [STATE_WIDTH-1:0]  i_wr_state [WRITE_PORTS],
    input  logic [ADDR_WIDTH-1:0]   i_wr_addr  [WRITE_PORTS],
    output logic                    o_head_valid [COMMIT_WIDTH],
    output logic [PTR_WIDTH-1:0]    o_head_ptr   [COMMIT_WIDTH],
    output logic [STATE_WIDTH-1:0]  o_head_state [COMMIT_WIDTH],
    output logic [ADDR_WIDTH-1:0]   o_head_addr  [COMMIT_WIDTH],
    input  logic [COMMIT_CNT_W-1:0] i_commit_count,
    input  logic                    i_flush_en,
    input  logic [PTR_WIDTH-1:0]    i_flush_ptr
);

    localparam int CNT_W = PTR_WIDTH + 1;

    logic [PTR_WIDTH-1:0]   r_head;
    logic [PTR_WIDTH-1:0]   r_tail;
    logic [CNT_W-1:0]       r_count;
    logic                   r_alloc [ENTRY_NUM];
    logic [STATE_WIDTH-1:0] r_state [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0]  r_addr  [ENTRY_NUM];

    logic                   w_alloc_nx [ENTRY_NUM];
    logic [STATE_WIDTH-1:0] w_state_nx [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0]  w_addr_nx  [ENTRY_NUM];

    logic [CNT_W-1:0]       w_free;
    logic [CNT_W-1:0]       w_nvalid;
    logic [CNT_W-1:0]       w_commit_req;
    logic [CNT_W-1:0]       w_commit_eff;
    logic [CNT_W-1:0]       w_alloc_req;
    logic [CNT_W-1:0]       w_alloc_n;
    logic                   w_alloc_ok;
    logic [PTR_WIDTH-1:0]   w_flush_off;

    // Head window: valid is a prefix chain, so the number of asserted bits is the retire limit.
    always_comb begin
        logic                 w_chain;
        logic [PTR_WIDTH-1:0] w_hidx;
        w_chain  = 1'b1;
        w_nvalid = '0;
        w_hidx   = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_hidx          = r_head + PTR_WIDTH'(i);
            o_head_ptr[i]   = w_hidx;
            o_head_state[i] = r_state[w_hidx];
            o_head_addr[i]  = r_addr[w_hidx];
            w_chain         = w_chain && (CNT_W'(i) < r_count) && (r_state[w_hidx] != '0);
            o_head_valid[i] = w_chain;
            if (w_chain) begin
                w_nvalid = w_nvalid + CNT_W'(1);
            end
        end
    end

    assign w_free       = CNT_W'(ENTRY_NUM) - r_count;
    assign w_commit_req = CNT_W'(i_commit_count);
    assign w_commit_eff = (w_commit_req > w_nvalid) ? w_nvalid : w_commit_req;
    assign w_alloc_req  = CNT_W'(i_alloc_count);
    // Space retired this cycle may be reused by a same-cycle allocation.
    assign w_alloc_ok   = (w_alloc_req <= (w_free + w_commit_eff));
    assign w_alloc_n    = w_alloc_ok ? w_alloc_req : '0;
    assign w_flush_off  = i_flush_ptr - r_head;

    assign o_tail_ptr   = r_tail;
    assign o_free_count = w_free;

    always_comb begin
        logic [PTR_WIDTH-1:0] w_idx;
        logic [PTR_WIDTH-1:0] w_off;
        w_idx = '0;
        w_off = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            w_alloc_nx[e] = r_alloc[e];
            w_state_nx[e] = r_state[e];
            w_addr_nx[e]  = r_addr[e];
        end
        // Ascending port order lets the highest port win a same-entry collision.
        for (int p = 0; p < WRITE_PORTS; p++) begin
            w_off = i_wr_ptr[p] - r_head;
            if (i_wr_en[p] && r_alloc[i_wr_ptr[p]] && (!i_flush_en || (w_off < w_flush_off))) begin
                w_state_nx[i_wr_ptr[p]] = i_wr_state[p];
                w_addr_nx[i_wr_ptr[p]]  = i_wr_addr[p];
            end
        end
        if (i_flush_en) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                w_off = PTR_WIDTH'(e) - r_head;
                if (w_off >= w_flush_off) begin
                    w_alloc_nx[e] = 1'b0;
                    w_state_nx[e] = '0;
                end
            end
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (CNT_W'(k) < w_commit_eff) begin
                    w_idx             = r_head + PTR_WIDTH'(k);
                    w_alloc_nx[w_idx] = 1'b0;
                    w_state_nx[w_idx] = '0;
                end
            end
            // Allocation is applied after retirement so a full table can recycle the head slots.
            for (int k = 0; k < ALLOC_WIDTH; k++) begin
                if (CNT_W'(k) < w_alloc_n) begin
                    w_idx             = r_tail + PTR_WIDTH'(k);
                    w_alloc_nx[w_idx] = 1'b1;
                    w_state_nx[w_idx] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush_en) begin
            r_tail  <= i_flush_ptr;
            r_count <= CNT_W'(w_flush_off);
        end else begin
            r_head  <= r_head + PTR_WIDTH'(w_commit_eff);
            r_tail  <= r_tail + PTR_WIDTH'(w_alloc_n);
            r_count <= r_count + w_alloc_n - w_commit_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                r_alloc[e] <= 1'b0;
                r_state[e] <= '0;
                r_addr[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                r_alloc[e] <= w_alloc_nx[e];
                r_state[e] <= w_state_nx[e];
                r_addr[e]  <= w_addr_nx[e];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && !i_flush_en) begin
            assert (w_alloc_ok)
            else $warning("mem_exec_state_table: alloc_count %0d exceeds free space, request dropped",
                          i_alloc_count);
        end
    end

endmodule

// File: tb/tb_mem_exec_state_table.sv
// Directed bench for mem_exec_state_table: allocation, completion writes, commit,
// flush truncation, full/wrap behaviour and asynchronous reset.
module tb_mem_exec_state_table;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alloc_count;
    logic [5:0]  tail_ptr;
    logic [6:0]  free_count;
    logic        wr_en    [2];
    logic [5:0]  wr_ptr   [2];
    logic [3:0]  wr_state [2];
    logic [31:0] wr_addr  [2];
    logic        head_valid [2];
    logic [5:0]  head_ptr   [2];
    logic [3:0]  head_state [2];
    logic [31:0] head_addr  [2];
    logic [1:0]  commit_count;
    logic        flush_en;
    logic [5:0]  flush_ptr;

    int n_checks;
    int n_errors;

    mem_exec_state_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_alloc_count  (alloc_count),
        .o_tail_ptr     (tail_ptr),
        .o_free_count   (free_count),
        .i_wr_en        (wr_en),
        .i_wr_ptr       (wr_ptr),
        .i_wr_state     (wr_state),
        .i_wr_addr      (wr_addr),
        .o_head_valid   (head_valid),
        .o_head_ptr     (head_ptr),
        .o_head_state   (head_state),
        .o_head_addr    (head_addr),
        .i_commit_count (commit_count),
        .i_flush_en     (flush_en),
        .i_flush_ptr    (flush_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        alloc_count  = 2'd0;
        commit_count = 2'd0;
        flush_en     = 1'b0;
        flush_ptr    = 6'd0;
        for (int p = 0; p < 2; p++) begin
            wr_en[p]    = 1'b0;
            wr_ptr[p]   = 6'd0;
            wr_state[p] = 4'd0;
            wr_addr[p]  = 32'd0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic wr(input int port, input int ptr, input int st, input int addr);
        wr_en[port]    = 1'b1;
        wr_ptr[port]   = 6'(ptr);
        wr_state[port] = 4'(st);
        wr_addr[port]  = 32'(addr);
    endtask

    task automatic alloc_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            alloc_count = 2'd2;
            cyc();
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clr();
        rst_n = 1'b0;
        #22;
        chk("rst_tail", 32'(tail_ptr), 0);
        chk("rst_free", 32'(free_count), 64);
        chk("rst_hv0", 32'(head_valid[0]), 0);
        chk("rst_hv1", 32'(head_valid[1]), 0);
        chk("rst_hptr0", 32'(head_ptr[0]), 0);
        chk("rst_hptr1", 32'(head_ptr[1]), 1);
        chk("rst_hstate0", 32'(head_state[0]), 0);
        chk("rst_haddr0", head_addr[0], 0);
        @(negedge clk);
        rst_n = 1'b1;

        // allocate 2 per cycle for 3 cycles
        alloc_cycles(3);
        chk("alloc_tail", 32'(tail_ptr), 6);
        chk("alloc_free", 32'(free_count), 58);
        chk("alloc_hv0", 32'(head_valid[0]), 0);
        chk("alloc_hv1", 32'(head_valid[1]), 0);

        // out-of-order completion, then in-order commit
        wr(0, 1, 1, 32'h100);
        cyc();
        chk("ooo_hv0", 32'(head_valid[0]), 0);
        chk("ooo_hv1", 32'(head_valid[1]), 0);
        wr(0, 0, 1, 32'h200);
        cyc();
        chk("inord_hv0", 32'(head_valid[0]), 1);
        chk("inord_hv1", 32'(head_valid[1]), 1);
        chk("inord_hstate1", 32'(head_state[1]), 1);
        chk("inord_haddr1", head_addr[1], 32'h100);
        commit_count = 2'd2;
        cyc();
        chk("commit_hptr0", 32'(head_ptr[0]), 2);
        chk("commit_free", 32'(free_count), 60);
        chk("commit_hv0", 32'(head_valid[0]), 0);

        // both ports hit ptr 5: port 1 wins
        wr(0, 5, 1, 32'h11);
        wr(1, 5, 3, 32'h33);
        cyc();
        wr(0, 2, 1, 32'h2);
        wr(1, 3, 1, 32'h3);
        cyc();
        commit_count = 2'd2;
        cyc();
        chk("coll_hptr0", 32'(head_ptr[0]), 4);
        chk("coll_hv0", 32'(head_valid[0]), 0);
        chk("coll_state", 32'(head_state[1]), 3);
        chk("coll_addr", head_addr[1], 32'h33);
        wr(0, 4, 1, 32'h4);
        cyc();
        chk("coll_hv1", 32'(head_valid[1]), 1);
        commit_count = 2'd2;
        cyc();
        chk("empty_free", 32'(free_count), 64);

        // excess commit is clamped to the number of valid heads
        alloc_cycles(2);
        wr(0, 6, 1, 32'h6);
        cyc();
        commit_count = 2'd2;
        cyc();
        chk("clamp_hptr0", 32'(head_ptr[0]), 7);
        chk("clamp_free", 32'(free_count), 61);
        wr(0, 7, 1, 32'h7);
        wr(1, 8, 1, 32'h8);
        cyc();
        commit_count = 2'd2;
        cyc();
        wr(0, 9, 1, 32'h9);
        cyc();
        commit_count = 2'd1;
        cyc();
        chk("pre_flush_hptr0", 32'(head_ptr[0]), 10);

        // entries 10..20, flush at 14 with same-cycle writes
        alloc_cycles(5);
        alloc_count = 2'd1;
        cyc();
        chk("pre_flush_tail", 32'(tail_ptr), 21);
        chk("pre_flush_free", 32'(free_count), 53);
        wr(0, 12, 2, 32'h12);
        wr(1, 15, 1, 32'h15);
        cyc();
        flush_en     = 1'b1;
        flush_ptr    = 6'd14;
        alloc_count  = 2'd2;
        commit_count = 2'd2;
        wr(0, 16, 1, 32'hAA16);
        wr(1, 13, 4, 32'h13);
        cyc();
        chk("flush_tail", 32'(tail_ptr), 14);
        chk("flush_free", 32'(free_count), 60);
        wr(0, 16, 1, 32'hBB16);
        cyc();
        wr(0, 10, 1, 32'h10);
        wr(1, 11, 1, 32'h11);
        cyc();
        commit_count = 2'd2;
        cyc();
        chk("flush_surv_state0", 32'(head_state[0]), 2);
        chk("flush_surv_state1", 32'(head_state[1]), 4);
        chk("flush_surv_addr1", head_addr[1], 32'h13);
        chk("flush_surv_hv1", 32'(head_valid[1]), 1);
        commit_count = 2'd2;
        cyc();
        chk("flush_drain_free", 32'(free_count), 64);
        chk("flush_cleared15", 32'(head_state[1]), 0);
        alloc_cycles(2);
        wr(0, 14, 1, 32'h14);
        wr(1, 15, 1, 32'h15);
        cyc();
        commit_count = 2'd2;
        cyc();
        chk("flush_hptr16", 32'(head_ptr[0]), 16);
        chk("flush_wr16_dropped", head_addr[0], 0);
        chk("flush_hv16", 32'(head_valid[0]), 0);

        // 30 live entries, then reset in the middle of a commit cycle
        alloc_cycles(14);
        chk("live30_free", 32'(free_count), 34);
        wr(0, 16, 1, 32'h16);
        wr(1, 17, 1, 32'h17);
        cyc();
        chk("live30_hv1", 32'(head_valid[1]), 1);
        commit_count = 2'd2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tail", 32'(tail_ptr), 0);
        chk("arst_free", 32'(free_count), 64);
        chk("arst_hv0", 32'(head_valid[0]), 0);
        chk("arst_hptr0", 32'(head_ptr[0]), 0);
        chk("arst_hptr1", 32'(head_ptr[1]), 1);
        chk("arst_haddr0", head_addr[0], 0);
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_tail", 32'(tail_ptr), 0);

        // fill from 0 to full, drop overflow, then commit+alloc across the wrap
        alloc_count = 2'd2;
        cyc();
        chk("rel_first_tail", 32'(tail_ptr), 2);
        chk("rel_first_hptr", 32'(head_ptr[0]), 0);
        alloc_cycles(31);
        chk("full_tail", 32'(tail_ptr), 0);
        chk("full_free", 32'(free_count), 0);
        alloc_count = 2'd1;
        cyc();
        chk("ovf_tail", 32'(tail_ptr), 0);
        chk("ovf_free", 32'(free_count), 0);
        wr(0, 0, 1, 32'h1000);
        wr(1, 1, 1, 32'h1001);
        cyc();
        commit_count = 2'd2;
        alloc_count  = 2'd2;
        cyc();
        chk("wrap_tail", 32'(tail_ptr), 2);
        chk("wrap_free", 32'(free_count), 0);
        chk("wrap_hptr0", 32'(head_ptr[0]), 2);
        chk("wrap_hv0", 32'(head_valid[0]), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
